// File: rtl/tt_io_pkg.sv
// Shared definitions for the Tiny Tapeout I/O front end: channel FSM
// encoding, default constants and the fixed pin positions of clk/rst_n.
package tt_io_pkg;

   // Per-channel debounce FSM: stable low, arming toward high, stable high,
   // arming toward low.
   typedef enum logic [1:0] {
      S_LO     = 2'd0,
      S_ARM_HI = 2'd1,
      S_HI     = 2'd2,
      S_ARM_LO = 2'd3
   } state_t;

   localparam int CHANNELS_DEF        = 6;
   localparam int DEBOUNCE_CYCLES_DEF = 8;
   localparam int CNT_W_DEF           = 8;
   localparam int EVT_W_DEF           = 4;

   // io_in bit positions consumed by the clock and reset at the top level.
   localparam int CLK_PIN  = 0;
   localparam int RSTN_PIN = 1;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, debounce FSM with a
// stability counter, registered clean level and one-cycle rise/fall pulses.
module debounce_channel
   import tt_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   input  logic enable,
   output logic clean,
   output logic rise,
   output logic fall
);

   // Acceptance happens when the counter already holds DEBOUNCE_CYCLES-1
   // and the synchronised level is still the candidate one.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_reg;
   logic             sync2_reg;
   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             clean_reg;
   logic             clean_next;
   logic             rise_reg;
   logic             rise_next;
   logic             fall_reg;
   logic             fall_next;
   logic             s;

   assign s = sync2_reg;

   // Synchroniser runs regardless of enable so a level changed while frozen
   // is visible immediately on resume.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_LO;
         cnt_reg   <= '0;
         clean_reg <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         clean_reg <= clean_next;
         rise_reg  <= rise_next;
         fall_reg  <= fall_next;
      end
   end

   // Next-state logic; everything holds while disabled.
   always_comb begin
      state_next = state_reg;
      if (enable) begin
         case (state_reg)
            S_LO: begin
               if (s) state_next = S_ARM_HI;
            end
            S_ARM_HI: begin
               if (!s)                       state_next = S_LO;
               else if (cnt_reg == CNT_LAST) state_next = S_HI;
            end
            S_HI: begin
               if (!s) state_next = S_ARM_LO;
            end
            S_ARM_LO: begin
               if (s)                        state_next = S_HI;
               else if (cnt_reg == CNT_LAST) state_next = S_LO;
            end
            default: state_next = S_LO;
         endcase
      end
   end

   // Counter, clean level and pulse values for the next cycle; pulses are
   // zero unless this cycle accepts a new level.
   always_comb begin
      cnt_next   = cnt_reg;
      clean_next = clean_reg;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      if (enable) begin
         case (state_reg)
            S_LO: begin
               if (s) cnt_next = CNT_ONE;
            end
            S_ARM_HI: begin
               if (!s) begin
                  cnt_next = '0;
               end else if (cnt_reg == CNT_LAST) begin
                  cnt_next   = '0;
                  clean_next = 1'b1;
                  rise_next  = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end
            S_HI: begin
               if (!s) cnt_next = CNT_ONE;
            end
            S_ARM_LO: begin
               if (s) begin
                  cnt_next = '0;
               end else if (cnt_reg == CNT_LAST) begin
                  cnt_next   = '0;
                  clean_next = 1'b0;
                  fall_next  = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end
            default: cnt_next = '0;
         endcase
      end
   end

   assign clean = clean_reg;
   assign rise  = rise_reg;
   assign fall  = fall_reg;

endmodule

// File: rtl/input_conditioner.sv
// Front-end conditioner for the raw io_in pins: one debounce_channel per
// input plus a wrapping count of accepted rising events across channels.
module input_conditioner
   import tt_io_pkg::*;
#(
   parameter int CHANNELS        = CHANNELS_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter int EVT_W           = EVT_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] raw_in,
   input  logic                enable,
   output logic [CHANNELS-1:0] clean_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic [EVT_W-1:0]    event_count
);

   logic [EVT_W-1:0] event_count_reg;
   logic [EVT_W-1:0] event_count_next;
   logic [EVT_W-1:0] rise_pop;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (raw_in[gi]),
            .enable (enable),
            .clean  (clean_out[gi]),
            .rise   (rise_pulse[gi]),
            .fall   (fall_pulse[gi])
         );
      end
   endgenerate

   // Popcount of this cycle's rise pulses; truncation to EVT_W is harmless
   // because the counter itself wraps modulo 2^EVT_W.
   always_comb begin
      rise_pop = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         rise_pop = rise_pop + EVT_W'(rise_pulse[i]);
      end
      event_count_next = event_count_reg + rise_pop;
   end

   // Aggregate event counter; frozen together with the channels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_count_reg <= '0;
      end else if (enable) begin
         event_count_reg <= event_count_next;
      end
   end

   assign event_count = event_count_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with default parameters
// (6 channels, 8-cycle debounce, 4-bit event counter).
module tb_input_conditioner;

   logic       clk;
   logic       rst_n;
   logic [5:0] raw_in;
   logic       enable;
   logic [5:0] clean_out;
   logic [5:0] rise_pulse;
   logic [5:0] fall_pulse;
   logic [3:0] event_count;

   int pass_count = 0;
   int check_count = 0;
   logic [5:0] seen_rise;
   logic [5:0] seen_fall;

   input_conditioner dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_in      (raw_in),
      .enable      (enable),
      .clean_out   (clean_out),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .event_count (event_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, sampling 1 ns after each; accumulate pulses seen.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         seen_rise = seen_rise | rise_pulse;
         seen_fall = seen_fall | fall_pulse;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clear_seen();
      seen_rise = '0;
      seen_fall = '0;
   endtask

   // Toggle one channel high until accepted, then low until accepted.
   task automatic rise_fall(input int ch);
      raw_in[ch] = 1'b1;
      tick(11);
      raw_in[ch] = 1'b0;
      tick(11);
   endtask

   // Apply an asynchronous reset pulse between clock edges.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #4;
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      clear_seen();
      enable = 1'b1;
      raw_in = 6'h3F;
      rst_n  = 1'b0;
      tick(3);
      // Reset state with all pins high.
      check("rst_clean", 32'(clean_out), 32'h00);
      check("rst_rise", 32'(rise_pulse), 32'h00);
      check("rst_fall", 32'(fall_pulse), 32'h00);
      check("rst_evt", 32'(event_count), 32'h0);

      // Release: first sample at the next edge, acceptance on the 10th.
      rst_n = 1'b1;
      tick(9);
      check("rel_clean_e9", 32'(clean_out), 32'h00);
      tick(1);
      check("rel_clean_e10", 32'(clean_out), 32'h3F);
      check("rel_rise_e10", 32'(rise_pulse), 32'h3F);
      tick(1);
      check("rel_rise_e11", 32'(rise_pulse), 32'h00);
      check("rel_evt", 32'(event_count), 32'h6);

      // Drop all: falls after the same latency, counter unaffected.
      raw_in = 6'h00;
      tick(10);
      check("fall_all_clean", 32'(clean_out), 32'h00);
      check("fall_all_pulse", 32'(fall_pulse), 32'h3F);
      tick(1);
      check("fall_all_pulse_off", 32'(fall_pulse), 32'h00);
      check("fall_all_evt", 32'(event_count), 32'h6);

      // 7-cycle glitch on ch0 is rejected.
      clear_seen();
      raw_in[0] = 1'b1;
      tick(7);
      raw_in[0] = 1'b0;
      tick(15);
      check("glitch_clean", 32'(clean_out), 32'h00);
      check("glitch_rise", 32'(seen_rise), 32'h00);
      check("glitch_fall", 32'(seen_fall), 32'h00);
      check("glitch_evt", 32'(event_count), 32'h6);

      // 12-cycle pulse on ch0: one-cycle rise then one-cycle fall.
      raw_in[0] = 1'b1;
      tick(9);
      check("p12_clean_e9", 32'(clean_out), 32'h00);
      tick(1);
      check("p12_rise", 32'(rise_pulse), 32'h01);
      check("p12_clean", 32'(clean_out), 32'h01);
      tick(1);
      check("p12_rise_off", 32'(rise_pulse), 32'h00);
      check("p12_evt", 32'(event_count), 32'h7);
      tick(1);
      raw_in[0] = 1'b0;
      tick(9);
      check("p12_hold_hi", 32'(clean_out), 32'h01);
      tick(1);
      check("p12_fall", 32'(fall_pulse), 32'h01);
      check("p12_clean_lo", 32'(clean_out), 32'h00);
      tick(1);
      check("p12_fall_off", 32'(fall_pulse), 32'h00);

      // Enable freeze on ch2: counter reaches 4, freeze 20 cycles, resume.
      raw_in[2] = 1'b1;
      tick(6);
      enable = 1'b0;
      clear_seen();
      tick(20);
      check("frz_clean", 32'(clean_out), 32'h00);
      check("frz_pulses", 32'({seen_rise, seen_fall}), 32'h000);
      check("frz_evt", 32'(event_count), 32'h7);
      enable = 1'b1;
      tick(3);
      check("frz_resume_e3", 32'(clean_out), 32'h00);
      tick(1);
      check("frz_resume_e4", 32'(clean_out), 32'h04);
      check("frz_resume_rise", 32'(rise_pulse), 32'h04);
      tick(1);
      check("frz_evt_after", 32'(event_count), 32'h8);

      // Fresh start for the wrap test.
      raw_in = 6'h00;
      do_reset();
      check("wrap_start_evt", 32'(event_count), 32'h0);
      for (int r = 0; r < 17; r++) rise_fall(1);
      check("wrap17_evt", 32'(event_count), 32'h1);
      for (int r = 0; r < 13; r++) rise_fall(1);
      check("wrap14_evt", 32'(event_count), 32'hE);
      raw_in[3] = 1'b1;
      raw_in[4] = 1'b1;
      tick(10);
      check("dual_rise", 32'(rise_pulse), 32'h18);
      tick(1);
      check("dual_wrap_evt", 32'(event_count), 32'h0);

      // Asynchronous reset while ch5 is arming (counter at 5).
      raw_in[5] = 1'b1;
      tick(7);
      check("arm_clean_pre", 32'(clean_out), 32'h18);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clean", 32'(clean_out), 32'h00);
      check("async_evt", 32'(event_count), 32'h0);
      #2;
      rst_n = 1'b1;
      tick(9);
      check("async_rel_e9", 32'(clean_out), 32'h00);
      tick(1);
      check("async_rel_e10", 32'(clean_out), 32'h38);
      check("async_rel_rise", 32'(rise_pulse), 32'h38);
      tick(1);
      check("async_rel_evt", 32'(event_count), 32'h3);

      // Fast toggling on all channels never gets through.
      raw_in = 6'h00;
      do_reset();
      clear_seen();
      for (int t = 0; t < 100; t++) begin
         if ((t % 3) == 0) raw_in = ~raw_in;
         tick(1);
         check("fast_clean", 32'(clean_out), 32'h00);
      end
      check("fast_pulses", 32'({seen_rise, seen_fall}), 32'h000);
      check("fast_evt", 32'(event_count), 32'h0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
